// File: rtl/alu_issue_controller_if.sv
// Bus bundle between the issue controller, its instruction source, the
// external ALU and writeback.
//   in_*      : decoded-instruction valid/ready handshake (source -> controller)
//   alu_*     : operand/select drive to the external ALU and its result
//   out_*     : registered result valid/ready handshake (controller -> writeback)
// The master modport is the environment side; slave is the controller.
interface alu_issue_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SEL_SIZE   = 4,
    parameter int unsigned SHIFT_SIZE = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_opcode;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [XLEN-1:0]       in_imm;
    logic [XLEN-1:0]       in_pc;
    logic [4:0]            in_rd;

    logic                  alu_enable;
    logic [SEL_SIZE-1:0]   alu_sel;
    logic [SHIFT_SIZE-1:0] alu_shift_amt;
    logic [XLEN-1:0]       alu_data_a;
    logic [XLEN-1:0]       alu_data_b;
    logic [XLEN-1:0]       alu_result;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_result;
    logic [4:0]            out_rd;
    logic                  out_illegal;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rs1_data,
               in_rs2_data, in_imm, in_pc, in_rd,
        input  in_ready,
        input  alu_enable, alu_sel, alu_shift_amt, alu_data_a, alu_data_b,
        output alu_result,
        input  out_valid, out_result, out_rd, out_illegal,
        output out_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1_data,
               in_rs2_data, in_imm, in_pc, in_rd,
        output in_ready,
        output alu_enable, alu_sel, alu_shift_amt, alu_data_a, alu_data_b,
        input  alu_result,
        output out_valid, out_result, out_rd, out_illegal,
        input  out_ready
    );
endinterface

// File: rtl/alu_issue_controller.sv
// Execute-stage sequencer for the 12-op ALU: decodes RV32I OP / OP-IMM /
// LUI / AUIPC into ALU select, shift amount and operands (issue stage S1),
// drives the external ALU from S1, and registers its result for writeback
// (result stage S2). Both stages honour backpressure and a synchronous flush.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   flush : kills every in-flight op at the next edge
//   bus   : alu_issue_if slave (instruction in, ALU drive, result out)
module alu_issue_controller #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SEL_SIZE   = 4,
    parameter int unsigned SHIFT_SIZE = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    alu_issue_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [SEL_SIZE-1:0] SEL_ADD   = SEL_SIZE'(0);
    localparam logic [SEL_SIZE-1:0] SEL_SUB   = SEL_SIZE'(1);
    localparam logic [SEL_SIZE-1:0] SEL_SLT   = SEL_SIZE'(2);
    localparam logic [SEL_SIZE-1:0] SEL_SLTU  = SEL_SIZE'(3);
    localparam logic [SEL_SIZE-1:0] SEL_AND   = SEL_SIZE'(4);
    localparam logic [SEL_SIZE-1:0] SEL_OR    = SEL_SIZE'(5);
    localparam logic [SEL_SIZE-1:0] SEL_XOR   = SEL_SIZE'(6);
    localparam logic [SEL_SIZE-1:0] SEL_SLL   = SEL_SIZE'(7);
    localparam logic [SEL_SIZE-1:0] SEL_SRL   = SEL_SIZE'(8);
    localparam logic [SEL_SIZE-1:0] SEL_SRA   = SEL_SIZE'(9);
    localparam logic [SEL_SIZE-1:0] SEL_LUI   = SEL_SIZE'(10);
    localparam logic [SEL_SIZE-1:0] SEL_AUIPC = SEL_SIZE'(11);

    // funct3 to ALU select; alt selects SUB/SRA on the shared encodings
    function automatic logic [SEL_SIZE-1:0] f3_sel(input logic [2:0] f3, input logic alt);
        logic [SEL_SIZE-1:0] s;
        case (f3)
            3'b000:  s = alt ? SEL_SUB : SEL_ADD;
            3'b001:  s = SEL_SLL;
            3'b010:  s = SEL_SLT;
            3'b011:  s = SEL_SLTU;
            3'b100:  s = SEL_XOR;
            3'b101:  s = alt ? SEL_SRA : SEL_SRL;
            3'b110:  s = SEL_OR;
            default: s = SEL_AND;
        endcase
        return s;
    endfunction

    // Decode of the offered instruction
    logic [SEL_SIZE-1:0]   dec_sel;
    logic [SHIFT_SIZE-1:0] dec_shamt;
    logic [XLEN-1:0]       dec_a;
    logic [XLEN-1:0]       dec_b;
    logic                  dec_illegal;
    logic                  dec_alt;

    always_comb begin
        dec_sel     = SEL_ADD;
        dec_shamt   = '0;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b0;
        dec_alt     = 1'b0;
        case (bus.in_opcode)
            OPC_OP: begin
                dec_a     = bus.in_rs1_data;
                dec_b     = bus.in_rs2_data;
                dec_shamt = bus.in_rs2_data[SHIFT_SIZE-1:0];
                dec_alt   = (bus.in_funct7 == F7_ALT);
                if (bus.in_funct7 == F7_ZERO) begin
                    dec_illegal = 1'b0;
                end else if (dec_alt && (bus.in_funct3 == 3'b000 || bus.in_funct3 == 3'b101)) begin
                    dec_illegal = 1'b0;
                end else begin
                    dec_illegal = 1'b1;
                end
                dec_sel = f3_sel(bus.in_funct3, dec_alt);
            end
            OPC_OP_IMM: begin
                dec_a     = bus.in_rs1_data;
                dec_b     = bus.in_imm;
                dec_shamt = bus.in_imm[SHIFT_SIZE-1:0];
                // funct7 is immediate payload except on the shift encodings
                dec_alt   = (bus.in_funct3 == 3'b101) && (bus.in_funct7 == F7_ALT);
                if (bus.in_funct3 == 3'b001 && bus.in_funct7 != F7_ZERO) begin
                    dec_illegal = 1'b1;
                end else if (bus.in_funct3 == 3'b101 && bus.in_funct7 != F7_ZERO
                             && bus.in_funct7 != F7_ALT) begin
                    dec_illegal = 1'b1;
                end
                dec_sel = f3_sel(bus.in_funct3, dec_alt);
            end
            OPC_LUI: begin
                dec_sel = SEL_LUI;
                dec_a   = XLEN'(bus.in_imm[19:0]);
            end
            OPC_AUIPC: begin
                dec_sel = SEL_AUIPC;
                dec_a   = XLEN'(bus.in_imm[19:0]);
                dec_b   = bus.in_pc;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Pipeline state
    logic                  s1_valid;
    logic [SEL_SIZE-1:0]   s1_sel;
    logic [SHIFT_SIZE-1:0] s1_shamt;
    logic [XLEN-1:0]       s1_a;
    logic [XLEN-1:0]       s1_b;
    logic [4:0]            s1_rd;
    logic                  s1_illegal;

    logic                  s2_valid;
    logic [XLEN-1:0]       s2_result;
    logic [4:0]            s2_rd;
    logic                  s2_illegal;

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic alu_en;

    always_comb begin
        s2_free = !s2_valid || bus.out_ready;
        s1_adv  = s1_valid && s2_free;
        accept  = bus.in_valid && bus.in_ready;
        alu_en  = s1_valid && !s1_illegal;
    end

    assign bus.in_ready = !flush && (!s1_valid || s2_free);

    // Issue stage: loads on accept, empties when it advances into S2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sel     <= '0;
            s1_shamt   <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_rd      <= '0;
            s1_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_sel     <= dec_sel;
            s1_shamt   <= dec_shamt;
            s1_a       <= dec_a;
            s1_b       <= dec_b;
            s1_rd      <= bus.in_rd;
            s1_illegal <= dec_illegal;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result stage: an out handshake in a flush cycle has already delivered,
    // so clearing s2_valid on flush loses nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_rd      <= '0;
            s2_illegal <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid   <= 1'b1;
            s2_result  <= s1_illegal ? '0 : bus.alu_result;
            s2_rd      <= s1_rd;
            s2_illegal <= s1_illegal;
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // ALU drive is zeroed whenever no legal op occupies S1
    assign bus.alu_enable    = alu_en;
    assign bus.alu_sel       = alu_en ? s1_sel   : '0;
    assign bus.alu_shift_amt = alu_en ? s1_shamt : '0;
    assign bus.alu_data_a    = alu_en ? s1_a     : '0;
    assign bus.alu_data_b    = alu_en ? s1_b     : '0;

    assign bus.out_valid   = s2_valid;
    assign bus.out_result  = s2_result;
    assign bus.out_rd      = s2_rd;
    assign bus.out_illegal = s2_illegal;
endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed bench for alu_issue_controller with a behavioural model of the
// external 12-op ALU. Inputs change 1 time unit after posedge; outputs are
// sampled on the following negedge.
module tb_alu_issue_controller;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(32), .SEL_SIZE(4), .SHIFT_SIZE(5)) bus ();

    alu_issue_controller #(.XLEN(32), .SEL_SIZE(4), .SHIFT_SIZE(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // External ALU model; garbage when disabled so leaks are visible
    always_comb begin
        if (!bus.alu_enable) begin
            bus.alu_result = 32'hDEADBEEF;
        end else begin
            case (bus.alu_sel)
                4'd0:    bus.alu_result = bus.alu_data_a + bus.alu_data_b;
                4'd1:    bus.alu_result = bus.alu_data_a - bus.alu_data_b;
                4'd2:    bus.alu_result = 32'($signed(bus.alu_data_a) < $signed(bus.alu_data_b));
                4'd3:    bus.alu_result = 32'(bus.alu_data_a < bus.alu_data_b);
                4'd4:    bus.alu_result = bus.alu_data_a & bus.alu_data_b;
                4'd5:    bus.alu_result = bus.alu_data_a | bus.alu_data_b;
                4'd6:    bus.alu_result = bus.alu_data_a ^ bus.alu_data_b;
                4'd7:    bus.alu_result = bus.alu_data_a << bus.alu_shift_amt;
                4'd8:    bus.alu_result = bus.alu_data_a >> bus.alu_shift_amt;
                4'd9:    bus.alu_result = 32'($signed(bus.alu_data_a) >>> bus.alu_shift_amt);
                4'd10:   bus.alu_result = bus.alu_data_a << 12;
                4'd11:   bus.alu_result = (bus.alu_data_a << 12) + bus.alu_data_b;
                default: bus.alu_result = 32'hDEADBEEF;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_opcode   = opc;
        bus.in_funct3   = f3;
        bus.in_funct7   = f7;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
        bus.in_imm      = imm;
        bus.in_pc       = pc;
        bus.in_rd       = rd;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] BR    = 7'b1100011;

    initial begin
        // Reset held two edges with an instruction offered
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        offer(OPI, 3'b000, 7'h7F, 32'd5, 32'd0, 32'hFFFFFFFD, 32'd0, 5'd1);
        edge_step();
        edge_step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        mid();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
        edge_step();
        mid();
        chk("rst_no_accept_en", 32'(bus.alu_enable), 32'd0);
        chk("rst_no_accept_ov", 32'(bus.out_valid), 32'd0);

        // Four back-to-back ops, no backpressure
        edge_step();
        offer(OPI, 3'b000, 7'h7F, 32'd5, 32'd0, 32'hFFFFFFFD, 32'd0, 5'd1);
        mid();
        chk("s_in_ready", 32'(bus.in_ready), 32'd1);
        edge_step();
        offer(OP, 3'b000, 7'b0100000, 32'd10, 32'd15, 32'd0, 32'd0, 5'd2);
        mid();
        chk("addi_en", 32'(bus.alu_enable), 32'd1);
        chk("addi_sel", 32'(bus.alu_sel), 32'd0);
        chk("addi_a", bus.alu_data_a, 32'd5);
        chk("addi_b", bus.alu_data_b, 32'hFFFFFFFD);
        chk("addi_not_yet", 32'(bus.out_valid), 32'd0);
        edge_step();
        offer(OPI, 3'b101, 7'b0100000, 32'h80000000, 32'd0, 32'h00000404, 32'd0, 5'd3);
        mid();
        chk("addi_ov", 32'(bus.out_valid), 32'd1);
        chk("addi_res", bus.out_result, 32'd2);
        chk("addi_rd", 32'(bus.out_rd), 32'd1);
        chk("sub_sel", 32'(bus.alu_sel), 32'd1);
        edge_step();
        offer(AUIPC, 3'b000, 7'h00, 32'd0, 32'd0, 32'h00000001, 32'h100, 5'd4);
        mid();
        chk("sub_res", bus.out_result, 32'hFFFFFFFB);
        chk("sub_rd", 32'(bus.out_rd), 32'd2);
        chk("srai_sel", 32'(bus.alu_sel), 32'd9);
        chk("srai_shamt", 32'(bus.alu_shift_amt), 32'd4);
        edge_step();
        bus.in_valid = 1'b0;
        mid();
        chk("srai_res", bus.out_result, 32'hF8000000);
        chk("srai_rd", 32'(bus.out_rd), 32'd3);
        chk("auipc_sel", 32'(bus.alu_sel), 32'd11);
        chk("auipc_a", bus.alu_data_a, 32'd1);
        chk("auipc_b", bus.alu_data_b, 32'h100);
        edge_step();
        mid();
        chk("auipc_ov", 32'(bus.out_valid), 32'd1);
        chk("auipc_res", bus.out_result, 32'h1100);
        chk("auipc_rd", 32'(bus.out_rd), 32'd4);
        edge_step();
        mid();
        chk("stream_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: three ops offered while writeback stalls
        edge_step();
        bus.out_ready = 1'b0;
        offer(OP, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 32'd0, 5'd5);
        mid();
        chk("bp_rdy0", 32'(bus.in_ready), 32'd1);
        edge_step();
        offer(OP, 3'b110, 7'h00, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd6);
        mid();
        chk("bp_rdy1", 32'(bus.in_ready), 32'd1);
        edge_step();
        offer(OP, 3'b100, 7'h00, 32'hFF, 32'h0F, 32'd0, 32'd0, 5'd7);
        mid();
        chk("bp_full_rdy", 32'(bus.in_ready), 32'd0);
        chk("bp_ov", 32'(bus.out_valid), 32'd1);
        chk("bp_res_hold0", bus.out_result, 32'd3);
        edge_step();
        mid();
        chk("bp_res_hold1", bus.out_result, 32'd3);
        chk("bp_rd_hold1", 32'(bus.out_rd), 32'd5);
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        edge_step();
        bus.out_ready = 1'b1;
        mid();
        chk("bp_release_rdy", 32'(bus.in_ready), 32'd1);
        chk("bp_res1", bus.out_result, 32'd3);
        edge_step();
        bus.in_valid = 1'b0;
        mid();
        chk("bp_res2", bus.out_result, 32'hFF);
        chk("bp_rd2", 32'(bus.out_rd), 32'd6);
        edge_step();
        mid();
        chk("bp_res3", bus.out_result, 32'hF0);
        chk("bp_rd3", 32'(bus.out_rd), 32'd7);
        edge_step();
        mid();
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // Illegal ops: branch opcode, then OP SLL with funct7=0100000
        edge_step();
        offer(BR, 3'b000, 7'h00, 32'h55, 32'h66, 32'd0, 32'd0, 5'd7);
        edge_step();
        offer(OP, 3'b001, 7'b0100000, 32'd1, 32'd1, 32'd0, 32'd0, 5'd9);
        mid();
        chk("ill_en", 32'(bus.alu_enable), 32'd0);
        chk("ill_sel", 32'(bus.alu_sel), 32'd0);
        chk("ill_a", bus.alu_data_a, 32'd0);
        edge_step();
        bus.in_valid = 1'b0;
        mid();
        chk("ill_ov", 32'(bus.out_valid), 32'd1);
        chk("ill_flag", 32'(bus.out_illegal), 32'd1);
        chk("ill_res", bus.out_result, 32'd0);
        chk("ill_rd", 32'(bus.out_rd), 32'd7);
        chk("ill2_en", 32'(bus.alu_enable), 32'd0);
        edge_step();
        mid();
        chk("ill2_flag", 32'(bus.out_illegal), 32'd1);
        chk("ill2_res", bus.out_result, 32'd0);
        chk("ill2_rd", 32'(bus.out_rd), 32'd9);
        edge_step();
        mid();
        chk("ill_drained", 32'(bus.out_valid), 32'd0);

        // Flush with both stages full and a new op offered
        edge_step();
        bus.out_ready = 1'b0;
        offer(OP, 3'b000, 7'h00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd10);
        edge_step();
        offer(OP, 3'b000, 7'h00, 32'd2, 32'd2, 32'd0, 32'd0, 5'd11);
        edge_step();
        flush = 1'b1;
        offer(OP, 3'b000, 7'h00, 32'd3, 32'd3, 32'd0, 32'd0, 5'd12);
        mid();
        chk("fl_rdy", 32'(bus.in_ready), 32'd0);
        chk("fl_s2_full", 32'(bus.out_valid), 32'd1);
        chk("fl_s1_full", 32'(bus.alu_enable), 32'd1);
        edge_step();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        offer(LUI, 3'b000, 7'h00, 32'd0, 32'd0, 32'h000ABCDE, 32'd0, 5'd13);
        mid();
        chk("fl_ov", 32'(bus.out_valid), 32'd0);
        chk("fl_s1_empty", 32'(bus.alu_enable), 32'd0);
        chk("fl_rdy_after", 32'(bus.in_ready), 32'd1);
        edge_step();
        bus.in_valid = 1'b0;
        mid();
        chk("lui_sel", 32'(bus.alu_sel), 32'd10);
        chk("lui_a", bus.alu_data_a, 32'h000ABCDE);
        chk("lui_b", bus.alu_data_b, 32'd0);
        chk("lui_no_ghost", 32'(bus.out_valid), 32'd0);
        edge_step();
        mid();
        chk("lui_ov", 32'(bus.out_valid), 32'd1);
        chk("lui_res", bus.out_result, 32'hABCDE000);
        chk("lui_rd", 32'(bus.out_rd), 32'd13);
        edge_step();
        mid();
        chk("fl_drained", 32'(bus.out_valid), 32'd0);

        // SLT vs SLTU on 0xFFFFFFFF vs 1
        edge_step();
        offer(OP, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd14);
        edge_step();
        offer(OP, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd15);
        mid();
        chk("slt_sel", 32'(bus.alu_sel), 32'd2);
        edge_step();
        bus.in_valid = 1'b0;
        mid();
        chk("sltu_sel", 32'(bus.alu_sel), 32'd3);
        chk("slt_res", bus.out_result, 32'd1);
        chk("slt_rd", 32'(bus.out_rd), 32'd14);
        edge_step();
        mid();
        chk("sltu_ov", 32'(bus.out_valid), 32'd1);
        chk("sltu_res", bus.out_result, 32'd0);
        chk("sltu_rd", 32'(bus.out_rd), 32'd15);
        edge_step();
        mid();
        chk("slt_drained", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
